// File: rtl/ring_seq_ctrl.sv
// Sequencer for a systolic ring of N PEs: clear, load, N compute steps, drain N results.
// Optional cycle counter on perf_cycles is built only when RING_SEQ_CTRL_PERF_EN is defined.
module ring_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          pe_rst,
    output logic          pe_load,
    output logic          pe_en,
    output logic          coeff_rd,
    output logic [CW-1:0] coeff_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pe_shift,
    output logic [CW-1:0] out_idx,
    output logic [15:0]   perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          pe_rst_q;
    logic          pe_load_q;
    logic          pe_en_q;
    logic          coeff_rd_q;
    logic [CW-1:0] coeff_addr_q;
    logic          out_valid_q;
    logic [CW-1:0] out_idx_q;

    // Every strobe is registered together with the state it belongs to, so an
    // output always reflects the state that is current in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pe_rst_q     <= 1'b0;
            pe_load_q    <= 1'b0;
            pe_en_q      <= 1'b0;
            coeff_rd_q   <= 1'b0;
            coeff_addr_q <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
        end else begin
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pe_rst_q     <= 1'b0;
            pe_load_q    <= 1'b0;
            pe_en_q      <= 1'b0;
            coeff_rd_q   <= 1'b0;
            coeff_addr_q <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_CLEAR;
                        pe_rst_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_LOAD;
                    pe_load_q <= 1'b1;
                end
                S_LOAD: begin
                    state_q    <= S_RUN;
                    cnt_q      <= '0;
                    pe_en_q    <= 1'b1;
                    coeff_rd_q <= 1'b1;
                end
                S_RUN: begin
                    if (cnt_q == LAST) begin
                        state_q     <= S_DRAIN;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        pe_en_q      <= 1'b1;
                        coeff_rd_q   <= 1'b1;
                        coeff_addr_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready && cnt_q == LAST) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else if (out_ready) begin
                        cnt_q       <= cnt_q + 1'b1;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= cnt_q + 1'b1;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= cnt_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_rst     = pe_rst_q;
    assign pe_load    = pe_load_q;
    assign pe_en      = pe_en_q;
    assign coeff_rd   = coeff_rd_q;
    assign coeff_addr = coeff_addr_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign pe_shift   = out_valid_q && out_ready;

`ifdef RING_SEQ_CTRL_PERF_EN
    logic [15:0] perf_q;

    // Cleared on the edge entering CLEAR, then one count per busy cycle up to and including DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (abort) begin
            perf_q <= perf_q;
        end else if (state_q == S_IDLE && start) begin
            perf_q <= '0;
        end else if (state_q != S_IDLE && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Bench for ring_seq_ctrl: per-cycle stimulus and expected output vectors are queued,
// then replayed and compared cycle by cycle.
module tb_ring_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int W  = 8 + 2 * CW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pe_rst;
    logic          pe_load;
    logic          pe_en;
    logic          coeff_rd;
    logic [CW-1:0] coeff_addr;
    logic          out_valid;
    logic          out_ready;
    logic          pe_shift;
    logic [CW-1:0] out_idx;
    logic [15:0]   perf_cycles;

    ring_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .pe_rst      (pe_rst),
        .pe_load     (pe_load),
        .pe_en       (pe_en),
        .coeff_rd    (coeff_rd),
        .coeff_addr  (coeff_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pe_shift    (pe_shift),
        .out_idx     (out_idx),
        .perf_cycles (perf_cycles)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus bits: {reset, start, abort, out_ready}
    logic [3:0]   stim_q[$];
    logic [W-1:0] exp_q[$];

    localparam logic [W-1:0] ZERO = '0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input string tag, input logic [15:0] exp);
        n_cmp++;
        if (perf_cycles !== exp) begin
            n_err++;
            $display("FAIL %s: got perf_cycles %0d expected %0d", tag, perf_cycles, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic b, input logic d, input logic r,
                                        input logic l, input logic e, input logic c,
                                        input logic [CW-1:0] a, input logic v,
                                        input logic [CW-1:0] i, input logic s);
        return {b, d, r, l, e, c, a, v, i, s};
    endfunction

    task automatic push(input logic [3:0] s, input logic [W-1:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // One full run from the IDLE cycle in which start is sampled through DONE.
    task automatic push_run(input int stall_idx, input int stall_len, input logic hold);
        logic [CW-1:0] k;
        push({2'b01, 2'b01}, ZERO);
        push({1'b0, hold, 2'b01}, mk(1, 0, 1, 0, 0, 0, '0, 0, '0, 0));
        push({1'b0, hold, 2'b01}, mk(1, 0, 0, 1, 0, 0, '0, 0, '0, 0));
        for (int j = 0; j < N; j++) begin
            k = CW'(j);
            push({1'b0, hold, 2'b01}, mk(1, 0, 0, 0, 1, 1, k, 0, '0, 0));
        end
        for (int j = 0; j < N; j++) begin
            k = CW'(j);
            if (j == stall_idx)
                for (int t = 0; t < stall_len; t++)
                    push({1'b0, hold, 2'b00}, mk(1, 0, 0, 0, 0, 0, '0, 1, k, 0));
            push({1'b0, hold, 2'b01}, mk(1, 0, 0, 0, 0, 0, '0, 1, k, 1));
        end
        push({1'b0, hold, 2'b01}, mk(1, 1, 0, 0, 0, 0, '0, 0, '0, 0));
    endtask

    // driver + scoreboard: drive after a rising edge, compare on the falling edge
    task automatic run_queue(input string name);
        logic [3:0]   s;
        logic [W-1:0] e;
        logic [W-1:0] got;
        int           idx;
        idx = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, start, abort, out_ready} = s;
            @(negedge clk);
            got = {busy, done, pe_rst, pe_load, pe_en, coeff_rd, coeff_addr,
                   out_valid, out_idx, pe_shift};
            e = exp_q.pop_front();
            check_eq($sformatf("%s c%0d", name, idx), got, e);
            idx++;
            @(posedge clk);
            #1;
        end
        {reset, start, abort, out_ready} = 4'b0001;
    endtask

    always @(posedge clk) cyc++;

    logic [15:0] perf_basic;
    logic [15:0] perf_stall;
    int          r_idx;
    int          r_len;

    initial begin
`ifdef RING_SEQ_CTRL_PERF_EN
        perf_basic = 16'd11;
        perf_stall = 16'd14;
`else
        perf_basic = 16'd0;
        perf_stall = 16'd0;
`endif
        {reset, start, abort, out_ready} = 4'b1101;
        repeat (2) @(posedge clk);
        #1;

        // reset state, start held during reset
        push(4'b1101, ZERO);
        push(4'b0001, ZERO);
        run_queue("reset");
        check_perf("perf_reset", 16'd0);

        // basic run: done at cycle 11, busy low at 12
        push_run(-1, 0, 1'b0);
        push(4'b0001, ZERO);
        run_queue("basic");
        check_perf("perf_basic", perf_basic);

        // backpressure: 3 stall cycles at out_idx 1, done at cycle 14
        push_run(1, 3, 1'b0);
        push(4'b0001, ZERO);
        run_queue("stall");
        check_perf("perf_stall", perf_stall);

        // abort during the RUN cycle presenting coeff_addr 2, then a normal run
        push(4'b0101, ZERO);
        push(4'b0001, mk(1, 0, 1, 0, 0, 0, '0, 0, '0, 0));
        push(4'b0001, mk(1, 0, 0, 1, 0, 0, '0, 0, '0, 0));
        push(4'b0001, mk(1, 0, 0, 0, 1, 1, 2'd0, 0, '0, 0));
        push(4'b0001, mk(1, 0, 0, 0, 1, 1, 2'd1, 0, '0, 0));
        push(4'b0011, mk(1, 0, 0, 0, 1, 1, 2'd2, 0, '0, 0));
        push(4'b0001, ZERO);
        push(4'b0001, ZERO);
        push_run(-1, 0, 1'b0);
        push(4'b0001, ZERO);
        run_queue("abort");
        check_perf("perf_after_abort", perf_basic);

        // start held high: back-to-back runs, done at 11, 23, 35
        repeat (3) push_run(-1, 0, 1'b1);
        push(4'b0001, ZERO);
        run_queue("b2b");

        // reset asserted in DRAIN with start high
        push(4'b0101, ZERO);
        push(4'b0001, mk(1, 0, 1, 0, 0, 0, '0, 0, '0, 0));
        push(4'b0001, mk(1, 0, 0, 1, 0, 0, '0, 0, '0, 0));
        for (int j = 0; j < N; j++)
            push(4'b0001, mk(1, 0, 0, 0, 1, 1, CW'(j), 0, '0, 0));
        push(4'b0001, mk(1, 0, 0, 0, 0, 0, '0, 1, 2'd0, 1));
        push(4'b1101, mk(1, 0, 0, 0, 0, 0, '0, 1, 2'd1, 1));
        push(4'b1101, ZERO);
        push(4'b0001, ZERO);
        push(4'b0001, ZERO);
        run_queue("rst_drain");
        check_perf("perf_rst_drain", 16'd0);

        // random backpressure
        for (int t = 0; t < 4; t++) begin
            r_idx = $urandom_range(0, N - 1);
            r_len = $urandom_range(1, 5);
            push_run(r_idx, r_len, 1'b0);
            push(4'b0001, ZERO);
            run_queue($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
